// File: rtl/gtech_scan_reg.sv
// gtech_scan_reg: scannable parallel-load register with a saturating shift counter.
// Optional parity output is built only when GTECH_SCAN_REG_PARITY_EN is defined.
module gtech_scan_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic                         CP,
  input  logic                         RST,
  input  logic [WIDTH-1:0]             D,
  input  logic                         EN,
  input  logic                         TE,
  input  logic                         TI,
  output logic [WIDTH-1:0]             Q,
  output logic [WIDTH-1:0]             QN,
  output logic                         TO,
  output logic [$clog2(WIDTH+1)-1:0]   SCNT,
  output logic                         SDONE,
  output logic                         PAR
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] shift_val;
  logic [CW-1:0]    cnt_r;

  // A one-bit register has no upper slice to keep, so a shift simply captures TI.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign shift_val = TI;
    end else begin : g_shift_wn
      assign shift_val = {q_r[WIDTH-2:0], TI};
    end
  endgenerate

  always_ff @(posedge CP) begin
    if (RST) begin
      q_r   <= RESET_VAL;
      cnt_r <= '0;
    end else if (TE) begin
      q_r <= shift_val;
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else if (EN) begin
      q_r   <= D;
      cnt_r <= '0;
    end
  end

  assign Q     = q_r;
  assign QN    = ~q_r;
  assign TO    = q_r[WIDTH-1];
  assign SCNT  = cnt_r;
  assign SDONE = (cnt_r == CNT_MAX);

`ifdef GTECH_SCAN_REG_PARITY_EN
  assign PAR = ^q_r;
`else
  assign PAR = 1'b0;
`endif

endmodule
